// File: rtl/w5300_bus_responder.sv
// rtl/w5300_bus_responder.sv - W5300 direct-mode bus responder: common regs, IDR, socket 0 with TX/RX FIFOs
module w5300_bus_responder #(
  parameter int          FIFO_DEPTH = 64,
  parameter int          READ_LAT   = 2,
  parameter logic [15:0] CHIP_ID    = 16'h5300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_rst_n,
  input  logic        cs_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [9:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        int_n,
  input  logic        peer_connect,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  S0_IMR  = 8'h1F;

  localparam logic [9:0] A_MR   = 10'h000, A_IR   = 10'h002, A_IMR  = 10'h004, A_IDR = 10'h0FE;
  localparam logic [9:0] A_S0MR = 10'h200, A_S0CR = 10'h202, A_S0IR = 10'h206, A_SSR = 10'h208;
  localparam logic [9:0] A_WRSR = 10'h220, A_FSR  = 10'h224, A_RSR  = 10'h228;
  localparam logic [9:0] A_TXF  = 10'h22E, A_RXF  = 10'h230;

  typedef enum logic [7:0] {
    SOCK_CLOSED = 8'h00,
    SOCK_INIT   = 8'h13,
    SOCK_LISTEN = 8'h14,
    SOCK_ESTAB  = 8'h17
  } sock_t;

  logic        rst;
  logic        cs_q, rd_q, wr_q, rd_act_q, wr_act_q;
  logic [9:0]  addr_q, wr_addr_l, rd_addr, rd_sel;
  logic [15:0] din_q, wr_data_l, rd_mux;
  logic [2:0]  lat_cnt;
  logic        rd_act, wr_act, rd_start, rd_done, wr_commit;
  logic [15:0] mr, imr, s0_mr, tx_wrsr, ir_word;
  logic [7:0]  s0_cr, s0_ir, ir_clr, ir_ev;
  sock_t       ssr;
  logic        cmd_pend, cmd_close, con_ev, sending, send_done;
  logic [AW:0] send_left, send_init, tx_free;
  logic [16:0] wr_words;
  logic [15:0] tx_mem [FIFO_DEPTH];
  logic [15:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        unused_addr0;

  assign rst          = !rst_n || !w_rst_n;
  assign unused_addr0 = addr[0];

  // An access needs exactly one strobe low; both low is treated as idle.
  assign rd_act    = !cs_q && !rd_q && wr_q;
  assign wr_act    = !cs_q && !wr_q && rd_q;
  assign rd_start  = rd_act && !rd_act_q;
  assign rd_done   = rd_act_q && !rd_act && rd_q;
  assign wr_commit = wr_act_q && !wr_act && wr_q;
  assign rd_sel    = rd_start ? addr_q : rd_addr;

  assign cmd_close = cmd_pend && (s0_cr == 8'h10);
  assign con_ev    = peer_connect && (ssr == SOCK_LISTEN);
  assign send_done = sending && (send_left == '0) && !cmd_pend;
  assign wr_words  = ({1'b0, tx_wrsr} + 17'd1) >> 1;
  assign send_init = (wr_words < 17'(tx_cnt)) ? wr_words[AW:0] : tx_cnt;

  assign tx_valid = sending && (send_left != '0);
  assign tx_data  = tx_mem[tx_rp];
  assign rx_ready = (rx_cnt != DEPTH_W) && (ssr == SOCK_ESTAB);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = wr_commit && (wr_addr_l == A_TXF) && (tx_cnt != DEPTH_W);
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_done && (rd_addr == A_RXF) && (rx_cnt != '0);
  assign tx_free  = DEPTH_W - tx_cnt;

  assign ir_word = {7'b0, |(s0_ir & S0_IMR), 8'b0};
  assign ir_clr  = (wr_commit && wr_addr_l == A_S0IR) ? wr_data_l[7:0] : 8'h00;
  assign ir_ev   = {3'b0, send_done, 1'b0, rx_push, cmd_close, con_ev};

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      A_MR:    rd_mux = mr;
      A_IR:    rd_mux = ir_word;
      A_IMR:   rd_mux = imr;
      A_IDR:   rd_mux = CHIP_ID;
      A_S0MR:  rd_mux = s0_mr;
      A_S0CR:  rd_mux = {8'h00, s0_cr};
      A_S0IR:  rd_mux = {8'h00, s0_ir};
      A_SSR:   rd_mux = {8'h00, ssr};
      A_WRSR:  rd_mux = tx_wrsr;
      A_FSR:   rd_mux = 16'({tx_free, 1'b0});
      A_RSR:   rd_mux = 16'({rx_cnt, 1'b0});
      A_RXF:   rd_mux = (rx_cnt != '0) ? rx_mem[rx_rp] : 16'h0000;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_data_l;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst || cmd_close) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= 1'b1; rd_q <= 1'b1; wr_q <= 1'b1;
      addr_q <= '0; din_q <= '0; rd_act_q <= 1'b0; wr_act_q <= 1'b0;
      wr_addr_l <= '0; wr_data_l <= '0; rd_addr <= '0; lat_cnt <= '0;
      data_out <= '0; data_oe <= 1'b0; int_n <= 1'b1;
      mr <= 16'h3800; imr <= '0; s0_mr <= '0; s0_cr <= '0; s0_ir <= '0;
      ssr <= SOCK_CLOSED; tx_wrsr <= '0;
      cmd_pend <= 1'b0; sending <= 1'b0; send_left <= '0;
    end else begin
      cs_q <= cs_n; rd_q <= rd_n; wr_q <= wr_n;
      addr_q <= {addr[9:1], 1'b0}; din_q <= data_in;
      rd_act_q <= rd_act; wr_act_q <= wr_act;
      if (wr_act) begin
        wr_addr_l <= addr_q;
        wr_data_l <= din_q;
      end

      // data_out is loaded once, when data_oe rises, and then held.
      if (rd_start) begin
        rd_addr <= addr_q;
        lat_cnt <= 3'(READ_LAT - 1);
        if (READ_LAT == 1) begin
          data_oe  <= 1'b1;
          data_out <= rd_mux;
        end
      end else if (!rd_act) begin
        lat_cnt <= '0;
        data_oe <= 1'b0;
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt == 3'd1) begin
          data_oe  <= 1'b1;
          data_out <= rd_mux;
        end
      end

      int_n <= ~|(ir_word & imr);
      s0_ir <= (s0_ir & ~ir_clr) | ir_ev;

      if (con_ev) ssr <= SOCK_ESTAB;

      if (send_done) begin
        sending <= 1'b0;
        s0_cr   <= '0;
        tx_wrsr <= '0;
      end else if (tx_pop) begin
        send_left <= send_left - 1'b1;
      end

      // Commands execute one cycle after the S0_CR write commits.
      if (cmd_pend) begin
        cmd_pend <= 1'b0;
        s0_cr    <= '0;
        case (s0_cr)
          8'h01: if (ssr == SOCK_CLOSED && s0_mr[3:0] == 4'd1) ssr <= SOCK_INIT;
          8'h02: if (ssr == SOCK_INIT) ssr <= SOCK_LISTEN;
          8'h10: begin
            ssr       <= SOCK_CLOSED;
            sending   <= 1'b0;
            send_left <= '0;
          end
          8'h20: if (ssr == SOCK_ESTAB && !sending) begin
            sending   <= 1'b1;
            send_left <= send_init;
            s0_cr     <= 8'h20;
          end
          default: ;
        endcase
        if (sending && s0_cr != 8'h10) s0_cr <= 8'h20;
      end

      if (wr_commit) begin
        case (wr_addr_l)
          A_MR:   mr      <= wr_data_l;
          A_IMR:  imr     <= wr_data_l;
          A_S0MR: s0_mr   <= wr_data_l;
          A_WRSR: tx_wrsr <= wr_data_l;
          A_S0CR: begin
            s0_cr    <= wr_data_l[7:0];
            cmd_pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/w5300_bus_responder.md
Name: w5300_bus_responder

Overview:
- Synthesizable responder for the W5300 16-bit direct-mode host bus: cs_n, rd_n, wr_n, addr[9:0] and data.
- Emulates the chip end of the bus: common registers, the IDR, and one TCP socket (socket 0) with TX/RX FIFOs and int_n generation.
- Used as the counterpart of the driver in benches and in FPGA loopback builds.
- Its stream side injects peer RX words and drains TX words, standing in for the network.

Parameters:
- FIFO_DEPTH, 64, depth in 16-bit words of each socket FIFO (power of two, ≥4)
- READ_LAT, 2, clk cycles from sampled rd_n fall to data_oe/data_out valid (1..4)
- CHIP_ID, 16'h5300, value returned by IDR

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- w_rst_n  in  1  chip reset from host, synchronous, active-low; same effect as rst_n
- cs_n  in  1  chip select, active-low
- rd_n  in  1  read strobe, active-low
- wr_n  in  1  write strobe, active-low
- addr  in  10  byte address; addr[0] ignored
- data_in  in  16  write data from host
- data_out  out  16  read data to host
- data_oe  out  1  drive enable for the external tri-state buffer
- int_n  out  1  interrupt, active-low
- peer_connect  in  1  one-cycle pulse: a remote peer connects
- rx_valid  in  1  stream word offered for socket RX
- rx_data  in  16  stream word
- rx_ready  out  1  RX FIFO can accept (not full, SSR=ESTABLISHED)
- tx_valid  out  1  TX stream word valid
- tx_data  out  16  TX stream word
- tx_ready  in  1  sink accepts tx_data

Behaviour:
- Reset: when rst_n or w_rst_n is low at a clk edge, all state is cleared.
  - Register reset values: MR=16'h3800, IMR=0, S0_MR=0, S0_CR=0, S0_IR=0, S0_SSR=8'h00, TX_WRSR=0.
  - Both FIFOs are emptied.
  - Output reset values: data_out=0, data_oe=0, int_n=1, tx_valid=0, rx_ready=0.
  - A reset during SEND aborts it; no further tx_valid is raised.
- Strobes are registered once, and edges are detected on the registered copies.
  - Access = cs_n low, with exactly one of rd_n or wr_n low.
  - When both rd_n and wr_n are low, the access is ignored and data_oe=0.
- Write: commits on the cycle the registered wr_n rises while cs_n was low. The committed data is data_in captured on the last cycle wr_n was low.
- Read:
  - data_oe rises READ_LAT cycles after the registered rd_n fall, and falls on the cycle after the registered rd_n rise.
  - data_out is held stable while data_oe=1.
  - Unmapped addresses read 0, and writes to them are dropped.
- Address map (byte addresses):
  - 0x000 MR, R/W.
  - 0x002 IR, read-only. bit8 = |(S0_IR & S0_IMR), where S0_IMR is fixed at 8'h1F.
  - 0x004 IMR, R/W.
  - 0x0FE IDR, reads CHIP_ID.
  - 0x200 S0_MR, R/W. [3:0]=1 selects TCP.
  - 0x202 S0_CR, R/W command register.
  - 0x206 S0_IR, write-1-to-clear. Bits: CON=0, DISCON=1, RECV=2, SENDOK=4.
  - 0x208 S0_SSR, read-only.
  - 0x220 TX_WRSR, R/W byte count.
  - 0x224 TX_FSR, read-only: free words*2.
  - 0x228 RX_RSR, read-only: stored words*2.
  - 0x22E TX_FIFO, write pushes one word.
  - 0x230 RX_FIFO: read returns the head word, and the pop happens on the rd_n rise.
- Command state machine, S0_SSR values: CLOSED=00, INIT=13, LISTEN=14, ESTABLISHED=17.
  - OPEN(01) in CLOSED with S0_MR[3:0]=1 → INIT.
  - LISTEN(02) in INIT → LISTEN.
  - CLOSE(10) in any state → CLOSED; flush both FIFOs; set DISCON.
  - SEND(20) in ESTABLISHED → SEND sub-state.
  - RECV(40) in ESTABLISHED: acknowledge only, no state change.
  - Any other command, or any command in the wrong state, is ignored.
  - S0_CR returns to 0 one cycle after commit, except SEND, which holds its value until SEND completes.
- peer_connect while LISTEN → ESTABLISHED and set CON. In any other state it is ignored.
- SEND transfer:
  - Words to send = min(ceil(TX_WRSR/2), TX FIFO count).
  - One word leaves per tx_valid&&tx_ready.
  - On completion: set SENDOK, clear S0_CR, clear TX_WRSR.
  - A zero-word SEND sets SENDOK the next cycle.
- RX inject: a word is accepted on rx_valid&&rx_ready, and RECV is set on each accept.
- FIFO limits:
  - TX_FIFO write when full: dropped.
  - RX_FIFO read when empty: returns 0 and does not pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop on the same FIFO keeps the count unchanged.
- Interrupt: int_n = ~|(IR & IMR), registered (1 cycle after the IR change).
- Event vs W1C on the same cycle: if an event and a W1C write hit the same S0_IR bit in the same cycle, the event wins and the bit stays set.

Test Plan:
- Reset, then read 0x0FE, READ_LAT=2 → data_oe high 2 cycles after the rd_n fall, data_out=16'h5300. Read 0x000 → 16'h3800.
- Write S0_MR=1, CR=01, then CR=02 → SSR reads 13 then 14. Pulse peer_connect → SSR=17, S0_IR=16'h0001. With IMR=16'h0100, int_n falls 1 cycle later. W1C 0x0001 to S0_IR → int_n returns high.
- Push 3 words (A1A1, B2B2, C3C3) to TX_FIFO, TX_WRSR=5, CR=20, tx_ready toggling → 3 words out in order, SENDOK set, CR reads 0, TX_FSR=(FIFO_DEPTH)*2.
- Inject 64 words with FIFO_DEPTH=64 → rx_ready drops after the 64th word, RX_RSR=128. Read RX_FIFO 65 times → 64 words in order, then 0, and RX_RSR=0.
- CR=10 mid-SEND, after 1 of 4 words → tx_valid low next cycle, SSR=00, DISCON set, both FIFOs empty.
- Assert w_rst_n low for 1 cycle mid-read → data_oe=0 next cycle and all registers at reset values. An access with rd_n and wr_n both low → no write, data_oe=0.
